// File: rtl/nn_result_checker.sv
// nn_result_checker: sweeps an address window of a layer output RAM and a
// golden-reference RAM in lockstep, compares signed words against a
// programmable tolerance and reports the error count and the first mismatch.
module nn_result_checker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 3,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_count,
  input  logic [DATA_W-1:0] cfg_tol,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              gold_en,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [DATA_W-1:0] gold_data,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              first_err_vld,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  localparam int unsigned DW1 = DATA_W + 1;
  localparam int unsigned CW  = ADDR_W + 1;
  localparam int unsigned TAP = RD_LAT - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0] tol_q, tol_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr_d [RD_LAT];
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              fe_vld_q, fe_vld_d;
  logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
  logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
  logic [DATA_W-1:0] fe_got_q, fe_got_d;

  logic [DATA_W:0]   diff_c;
  logic [DATA_W:0]   mag_c;
  logic              mism_c;
  logic              inflight_c;

  // Tolerance compare in DATA_W+1 bits so full-scale differences cannot overflow
  always_comb begin
    diff_c = {ram_data[DATA_W-1], ram_data} - {gold_data[DATA_W-1], gold_data};
    mag_c  = diff_c[DATA_W] ? DW1'(~diff_c + DW1'(1)) : diff_c;
    mism_c = mag_c > {1'b0, tol_q};
  end

  // Reads still travelling toward the tap (the tap itself is compared this cycle)
  always_comb begin
    inflight_c = 1'b0;
    for (int unsigned i = 0; i < TAP; i++) begin
      inflight_c = inflight_c | vld_q[i];
    end
  end

  // Next-state, issue sequencing, valid pipeline and result bookkeeping
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    tol_d     = tol_q;
    err_cnt_d = err_cnt_q;
    fe_vld_d  = fe_vld_q;
    fe_addr_d = fe_addr_q;
    fe_exp_d  = fe_exp_q;
    fe_got_d  = fe_got_q;

    vld_d[0]       = en_q;
    pipe_addr_d[0] = addr_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i]       = vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end

    if (vld_q[TAP] && mism_c) begin
      if (err_cnt_q != {ERR_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
      if (!fe_vld_q) begin
        fe_vld_d  = 1'b1;
        fe_addr_d = pipe_addr_q[TAP];
        fe_exp_d  = gold_data;
        fe_got_d  = ram_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          tol_d     = cfg_tol;
          addr_d    = cfg_base;
          rem_d     = cfg_count;
          err_cnt_d = '0;
          fe_vld_d  = 1'b0;
          fe_addr_d = '0;
          fe_exp_d  = '0;
          fe_got_d  = '0;
          state_d   = (cfg_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (rem_q == CW'(1)) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - CW'(1);
        end
      end
      DRAIN: begin
        if (!inflight_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    en_d   = (state_d == ISSUE);
    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any sweep and clears in-flight reads
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      tol_q     <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= '0;
      err_cnt_q <= '0;
      fe_vld_q  <= 1'b0;
      fe_addr_q <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      tol_q     <= tol_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      err_cnt_q <= err_cnt_d;
      fe_vld_q  <= fe_vld_d;
      fe_addr_q <= fe_addr_d;
      fe_exp_q  <= fe_exp_d;
      fe_got_q  <= fe_got_d;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  assign ram_en         = en_q;
  assign gold_en        = en_q;
  assign ram_addr       = addr_q;
  assign gold_addr      = addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_vld  = fe_vld_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;

endmodule

// File: tb/tb_nn_result_checker.sv
// Directed bench for nn_result_checker: three instances (RD_LAT 3/1/7) with
// behavioural RAMs of matching latency; garbage is driven when not enabled.
module tb_nn_result_checker;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        start_m, start_1, start_7;
  logic [15:0] cfg_base;
  logic [16:0] cfg_count;
  logic [7:0]  cfg_tol;

  always #5 sys_clk = ~sys_clk;

  logic [7:0] res_mem  [0:65535];
  logic [7:0] gold_mem [0:65535];

  // main instance, RD_LAT=3, ERR_W=16
  logic        m_ram_en, m_gold_en, m_busy, m_done, m_fe_vld;
  logic [15:0] m_ram_addr, m_gold_addr, m_fe_addr, m_err;
  logic [7:0]  m_ram_data, m_gold_data, m_fe_exp, m_fe_got;
  // RD_LAT=1, ERR_W=4
  logic        a_ram_en, a_gold_en, a_busy, a_done, a_fe_vld;
  logic [15:0] a_ram_addr, a_gold_addr, a_fe_addr;
  logic [3:0]  a_err;
  logic [7:0]  a_ram_data, a_gold_data, a_fe_exp, a_fe_got;
  // RD_LAT=7, ERR_W=4
  logic        b_ram_en, b_gold_en, b_busy, b_done, b_fe_vld;
  logic [15:0] b_ram_addr, b_gold_addr, b_fe_addr;
  logic [3:0]  b_err;
  logic [7:0]  b_ram_data, b_gold_data, b_fe_exp, b_fe_got;

  nn_result_checker #(.DATA_W(8), .ADDR_W(16), .RD_LAT(3), .ERR_W(16)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_m),
    .cfg_base(cfg_base), .cfg_count(cfg_count), .cfg_tol(cfg_tol),
    .ram_en(m_ram_en), .ram_addr(m_ram_addr), .ram_data(m_ram_data),
    .gold_en(m_gold_en), .gold_addr(m_gold_addr), .gold_data(m_gold_data),
    .busy(m_busy), .done(m_done), .err_cnt(m_err),
    .first_err_vld(m_fe_vld), .first_err_addr(m_fe_addr),
    .first_err_exp(m_fe_exp), .first_err_got(m_fe_got));

  nn_result_checker #(.DATA_W(8), .ADDR_W(16), .RD_LAT(1), .ERR_W(4)) dut_l1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_1),
    .cfg_base(cfg_base), .cfg_count(cfg_count), .cfg_tol(cfg_tol),
    .ram_en(a_ram_en), .ram_addr(a_ram_addr), .ram_data(a_ram_data),
    .gold_en(a_gold_en), .gold_addr(a_gold_addr), .gold_data(a_gold_data),
    .busy(a_busy), .done(a_done), .err_cnt(a_err),
    .first_err_vld(a_fe_vld), .first_err_addr(a_fe_addr),
    .first_err_exp(a_fe_exp), .first_err_got(a_fe_got));

  nn_result_checker #(.DATA_W(8), .ADDR_W(16), .RD_LAT(7), .ERR_W(4)) dut_l7 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_7),
    .cfg_base(cfg_base), .cfg_count(cfg_count), .cfg_tol(cfg_tol),
    .ram_en(b_ram_en), .ram_addr(b_ram_addr), .ram_data(b_ram_data),
    .gold_en(b_gold_en), .gold_addr(b_gold_addr), .gold_data(b_gold_data),
    .busy(b_busy), .done(b_done), .err_cnt(b_err),
    .first_err_vld(b_fe_vld), .first_err_addr(b_fe_addr),
    .first_err_exp(b_fe_exp), .first_err_got(b_fe_got));

  // Behavioural read ports with fixed latency; random data when not enabled
  logic [7:0] m_rd [3];
  logic [7:0] m_gd [3];
  logic [7:0] a_rd [1];
  logic [7:0] a_gd [1];
  logic [7:0] b_rd [7];
  logic [7:0] b_gd [7];

  always @(posedge sys_clk) begin
    m_rd[0] <= m_ram_en  ? res_mem[m_ram_addr]   : 8'($urandom);
    m_gd[0] <= m_gold_en ? gold_mem[m_gold_addr] : 8'($urandom);
    for (int i = 1; i < 3; i++) begin
      m_rd[i] <= m_rd[i-1];
      m_gd[i] <= m_gd[i-1];
    end
    a_rd[0] <= a_ram_en  ? res_mem[a_ram_addr]   : 8'($urandom);
    a_gd[0] <= a_gold_en ? gold_mem[a_gold_addr] : 8'($urandom);
    b_rd[0] <= b_ram_en  ? res_mem[b_ram_addr]   : 8'($urandom);
    b_gd[0] <= b_gold_en ? gold_mem[b_gold_addr] : 8'($urandom);
    for (int i = 1; i < 7; i++) begin
      b_rd[i] <= b_rd[i-1];
      b_gd[i] <= b_gd[i-1];
    end
  end

  assign m_ram_data  = m_rd[2];
  assign m_gold_data = m_gd[2];
  assign a_ram_data  = a_rd[0];
  assign a_gold_data = a_gd[0];
  assign b_ram_data  = b_rd[6];
  assign b_gold_data = b_gd[6];

  // Instance selection for the shared sweep runner and read monitor
  int          sel;
  logic        done_s, busy_s, en_s, gen_s;
  logic [15:0] addr_s, gaddr_s;
  always_comb begin
    case (sel)
      1:       {done_s, busy_s, en_s, gen_s, addr_s, gaddr_s} = {a_done, a_busy, a_ram_en, a_gold_en, a_ram_addr, a_gold_addr};
      2:       {done_s, busy_s, en_s, gen_s, addr_s, gaddr_s} = {b_done, b_busy, b_ram_en, b_gold_en, b_ram_addr, b_gold_addr};
      default: {done_s, busy_s, en_s, gen_s, addr_s, gaddr_s} = {m_done, m_busy, m_ram_en, m_gold_en, m_ram_addr, m_gold_addr};
    endcase
  end

  logic        mon_on;
  int          en_cnt, gold_bad;
  logic [15:0] addrs [$];

  always @(negedge sys_clk) begin
    if (mon_on && en_s) begin
      en_cnt++;
      addrs.push_back(addr_s);
      if (!gen_s || gaddr_s !== addr_s) gold_bad++;
    end
  end

  int checks = 0;
  int errors = 0;

  // Pulse start on instance s (edge 0) and return the cycle in which done is seen
  task automatic run(input int s, input logic [15:0] base, input logic [16:0] cnt,
                     input logic [7:0] tol, input int extra_at,
                     output int done_n, output int busy_bad);
    sel = s; cfg_base = base; cfg_count = cnt; cfg_tol = tol;
    en_cnt = 0; gold_bad = 0; busy_bad = 0; addrs.delete();
    @(negedge sys_clk);
    case (s)
      1:       start_1 = 1'b1;
      2:       start_7 = 1'b1;
      default: start_m = 1'b1;
    endcase
    @(posedge sys_clk);
    #1;
    start_m = 1'b0; start_1 = 1'b0; start_7 = 1'b0;
    mon_on = 1'b1;
    done_n = 0;
    do begin
      @(negedge sys_clk);
      done_n++;
      start_m = (done_n == extra_at);
      if (done_n == extra_at) begin
        cfg_base = 16'h0100; cfg_count = 17'd2; cfg_tol = 8'd200;
      end
      if (done_s ? busy_s : !busy_s) busy_bad++;
    end while (!done_s && done_n < 300);
    start_m = 1'b0;
    mon_on = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({m_ram_en, m_gold_en, m_ram_addr, m_gold_addr, m_busy, m_done, m_err,
         m_fe_vld, m_fe_addr, m_fe_exp, m_fe_got} !== '0) begin
      errors++; $display("FAIL reset_outputs: main outputs not all zero (busy=%0b done=%0b en=%0b err=%0d)", m_busy, m_done, m_ram_en, m_err);
    end
    checks++;
    if ({a_busy, a_done, a_err, b_busy, b_done, b_err} !== '0) begin
      errors++; $display("FAIL reset_aux: aux instance outputs not zero");
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_match();
    int dn, bb, bad;
    run(0, 16'd0, 17'd24, 8'd0, -1, dn, bb);
    checks++; if (dn !== 28) begin errors++; $display("FAIL match_done_cycle: got %0d want 28", dn); end
    checks++; if (m_err !== 16'd0) begin errors++; $display("FAIL match_err_cnt: got %0d want 0", m_err); end
    checks++; if (m_fe_vld !== 1'b0) begin errors++; $display("FAIL match_fe_vld: got %0b want 0", m_fe_vld); end
    checks++; if (en_cnt !== 24) begin errors++; $display("FAIL match_en_cnt: got %0d want 24", en_cnt); end
    bad = 0;
    for (int i = 0; i < 24; i++) if (i >= addrs.size() || addrs[i] !== 16'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL match_addrs: %0d wrong of 24 (want 0..23)", bad); end
    checks++; if (gold_bad != 0) begin errors++; $display("FAIL match_gold_port: %0d cycles golden port differs, want 0", gold_bad); end
    checks++; if (bb != 0) begin errors++; $display("FAIL match_busy: %0d bad busy cycles, want 0", bb); end
  endtask

  task automatic test_inject();
    int dn, bb;
    res_mem[5]  = 8'hFD; gold_mem[5]  = 8'd4;
    res_mem[17] = 8'd100; gold_mem[17] = 8'd99;
    run(0, 16'd0, 17'd24, 8'd0, -1, dn, bb);
    checks++; if (m_err !== 16'd2) begin errors++; $display("FAIL inject_err_cnt: got %0d want 2", m_err); end
    checks++; if ({m_fe_vld, m_fe_addr} !== {1'b1, 16'd5}) begin errors++; $display("FAIL inject_fe_addr: got vld=%0b addr=%0d want 1/5", m_fe_vld, m_fe_addr); end
    checks++; if ({m_fe_exp, m_fe_got} !== {8'd4, 8'hFD}) begin errors++; $display("FAIL inject_fe_data: got exp=%0h got=%0h want 04/fd", m_fe_exp, m_fe_got); end
  endtask

  task automatic test_tolerance();
    int dn, bb;
    run(0, 16'd0, 17'd24, 8'd1, -1, dn, bb);
    checks++; if (m_err !== 16'd1) begin errors++; $display("FAIL tol1_err_cnt: got %0d want 1", m_err); end
    checks++; if (m_fe_addr !== 16'd5) begin errors++; $display("FAIL tol1_fe_addr: got %0d want 5", m_fe_addr); end
    res_mem[16'h8000] = 8'h80; gold_mem[16'h8000] = 8'h7F;
    res_mem[16'h8001] = 8'h7F; gold_mem[16'h8001] = 8'h80;
    run(0, 16'h8001, 17'd1, 8'd255, -1, dn, bb);
    checks++; if ({m_err, m_fe_vld} !== {16'd0, 1'b0}) begin errors++; $display("FAIL extreme_tol255: got err=%0d vld=%0b want 0/0", m_err, m_fe_vld); end
    run(0, 16'h8000, 17'd1, 8'd127, -1, dn, bb);
    checks++; if (dn !== 5) begin errors++; $display("FAIL extreme_done_cycle: got %0d want 5", dn); end
    checks++; if (m_err !== 16'd1) begin errors++; $display("FAIL extreme_err_cnt: got %0d want 1", m_err); end
    checks++; if ({m_fe_addr, m_fe_exp, m_fe_got} !== {16'h8000, 8'h7F, 8'h80}) begin
      errors++; $display("FAIL extreme_fe: got addr=%0h exp=%0h got=%0h want 8000/7f/80", m_fe_addr, m_fe_exp, m_fe_got);
    end
  endtask

  task automatic test_wrap();
    int dn, bb, bad;
    logic [15:0] exp_a [4];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    res_mem[16'hFFFE] = 8'd9; gold_mem[16'hFFFE] = 8'd9;
    res_mem[16'hFFFF] = 8'd1; gold_mem[16'hFFFF] = 8'd0;
    run(0, 16'hFFFE, 17'd4, 8'd0, -1, dn, bb);
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= addrs.size() || addrs[i] !== exp_a[i]) bad++;
    checks++; if (bad != 0 || en_cnt != 4) begin errors++; $display("FAIL wrap_addrs: %0d wrong, en_cnt=%0d want 0/4", bad, en_cnt); end
    checks++; if (dn !== 8) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 8", dn); end
    checks++; if ({m_err, m_fe_addr} !== {16'd1, 16'hFFFF}) begin errors++; $display("FAIL wrap_err: got err=%0d addr=%0h want 1/ffff", m_err, m_fe_addr); end
  endtask

  task automatic test_count_zero();
    int dn, bb;
    run(0, 16'd3, 17'd0, 8'd0, -1, dn, bb);
    checks++; if (dn !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", dn); end
    checks++; if ({m_err, m_fe_vld} !== {16'd0, 1'b0}) begin errors++; $display("FAIL zero_results: got err=%0d vld=%0b want 0/0", m_err, m_fe_vld); end
    checks++; if (en_cnt !== 0 || bb != 0) begin errors++; $display("FAIL zero_en: got en_cnt=%0d busy_bad=%0d want 0/0", en_cnt, bb); end
  endtask

  task automatic test_start_busy();
    int dn, bb;
    run(0, 16'd0, 17'd24, 8'd0, 5, dn, bb);
    checks++; if (dn !== 28 || en_cnt !== 24) begin errors++; $display("FAIL busy_start_timing: got done=%0d en=%0d want 28/24", dn, en_cnt); end
    checks++; if ({m_err, m_fe_addr} !== {16'd2, 16'd5}) begin errors++; $display("FAIL busy_start_results: got err=%0d addr=%0d want 2/5", m_err, m_fe_addr); end
  endtask

  task automatic test_saturation();
    int dn, bb;
    for (int i = 0; i < 20; i++) begin
      gold_mem[16'h1000 + 16'(i)] = 8'(i);
      res_mem[16'h1000 + 16'(i)]  = 8'(i + 5);
    end
    run(0, 16'h1000, 17'd20, 8'd0, -1, dn, bb);
    checks++; if (dn !== 24 || m_err !== 16'd20) begin errors++; $display("FAIL sat_main: got done=%0d err=%0d want 24/20", dn, m_err); end
    run(1, 16'h1000, 17'd20, 8'd0, -1, dn, bb);
    checks++; if (dn !== 22 || a_err !== 4'd15) begin errors++; $display("FAIL sat_lat1: got done=%0d err=%0d want 22/15", dn, a_err); end
    checks++; if (bb != 0) begin errors++; $display("FAIL sat_lat1_busy: %0d bad busy cycles want 0", bb); end
    run(2, 16'h1000, 17'd20, 8'd0, -1, dn, bb);
    checks++; if (dn !== 28 || b_err !== 4'd15) begin errors++; $display("FAIL sat_lat7: got done=%0d err=%0d want 28/15", dn, b_err); end
    checks++; if ({b_fe_addr, b_fe_exp, b_fe_got} !== {16'h1000, 8'd0, 8'd5}) begin
      errors++; $display("FAIL sat_lat7_fe: got addr=%0h exp=%0d got=%0d want 1000/0/5", b_fe_addr, b_fe_exp, b_fe_got);
    end
  endtask

  task automatic test_reset_mid();
    int dn, bb, n, done_seen;
    sel = 0; cfg_base = 16'd0; cfg_count = 17'd24; cfg_tol = 8'd0;
    @(negedge sys_clk);
    start_m = 1'b1;
    @(posedge sys_clk);
    #1 start_m = 1'b0;
    for (n = 1; n <= 11; n++) @(negedge sys_clk);
    checks++; if (m_ram_addr !== 16'd10 || m_ram_en !== 1'b1) begin errors++; $display("FAIL midrst_pre: got en=%0b addr=%0d want 1/10", m_ram_en, m_ram_addr); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_ram_en, m_gold_en, m_ram_addr, m_gold_addr, m_busy, m_done, m_err,
         m_fe_vld, m_fe_addr, m_fe_exp, m_fe_got} !== '0) begin
      errors++; $display("FAIL midrst_outputs: not all zero (en=%0b busy=%0b err=%0d)", m_ram_en, m_busy, m_err);
    end
    done_seen = 0;
    repeat (3) begin @(negedge sys_clk); if (m_done) done_seen++; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge sys_clk); if (m_done || m_busy) done_seen++; end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done/busy cycles want 0", done_seen); end
    run(0, 16'd0, 17'd24, 8'd0, -1, dn, bb);
    checks++; if (dn !== 28 || m_err !== 16'd2 || m_fe_addr !== 16'd5) begin
      errors++; $display("FAIL midrst_rerun: got done=%0d err=%0d addr=%0d want 28/2/5", dn, m_err, m_fe_addr);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_m = 1'b0; start_1 = 1'b0; start_7 = 1'b0;
    cfg_base = '0; cfg_count = '0; cfg_tol = '0; sel = 0; mon_on = 1'b0;
    en_cnt = 0; gold_bad = 0;
    for (int i = 0; i < 65536; i++) begin
      res_mem[i]  = 8'(i * 11 - 100);
      gold_mem[i] = 8'(i * 11 - 100);
    end
    test_reset();
    test_match();
    test_inject();
    test_tolerance();
    test_wrap();
    test_count_zero();
    test_start_busy();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_result_checker.md
Name: nn_result_checker

Overview:
- Synthesizable on-chip result checker for the CNN pipeline.
- After a layer finishes (for example, end_ConV1 or a max-pool stage), it sweeps a configurable address window of the layer output RAM and, in lockstep, the same window of a golden-reference RAM.
- Compares signed words within a programmable tolerance and reports the error count, the first mismatch and completion status.
- Replaces bench-side readback. It is parametrised in data width, address width, RAM read latency and error-counter width.

Parameters:
DATA_W, 8, signed word width of result and golden data
ADDR_W, 16, address width of both RAM read ports
RD_LAT, 3, read latency in cycles from en/addr sampled to data valid (1..7)
ERR_W, 16, error counter width (saturating)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
cfg_base  in  ADDR_W  first address to check, latched at start
cfg_count  in  ADDR_W+1  number of words to check (0..2^ADDR_W), latched at start
cfg_tol  in  DATA_W  unsigned tolerance; a word passes if |got-exp| <= tol, latched at start
ram_en  out  1  result RAM read enable
ram_addr  out  ADDR_W  result RAM read address
ram_data  in  DATA_W  signed result RAM read data
gold_en  out  1  golden RAM read enable (identical timing to ram_en)
gold_addr  out  ADDR_W  golden RAM read address (equals ram_addr)
gold_data  in  DATA_W  signed golden read data
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse when the sweep completes
err_cnt  out  ERR_W  mismatching words in the last sweep, saturates at all-ones
first_err_vld  out  1  at least one mismatch recorded
first_err_addr  out  ADDR_W  address of the first mismatch
first_err_exp  out  DATA_W  golden value at the first mismatch
first_err_got  out  DATA_W  result value at the first mismatch

Behaviour:
- Reset (async, rst_n=0):
  - The FSM goes to IDLE.
  - All outputs are 0: ram_en, gold_en, addresses, busy, done, err_cnt, first_err_*.
  - The valid pipeline is cleared.
- Reset mid-sweep aborts immediately. In-flight returns are discarded and no done pulse is produced.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - When start=1, latch cfg_*, clear err_cnt and first_err_*, and set busy.
  - If cfg_count=0, go to DONE. Otherwise go to ISSUE.
  - start in any other state is ignored, with no effect on the sweep.
- ISSUE:
  - Each cycle, ram_en=gold_en=1 and addr = base+i for i = 0..count-1, one address per cycle with no bubbles.
  - Addresses wrap modulo 2^ADDR_W.
  - After the last issue, go to DRAIN.
- Valid pipeline:
  - An RD_LAT-deep shift register carries issue-valid plus the issued address.
  - The compare takes place in the cycle where the tap is set, using ram_data and gold_data as sampled on that edge.
- DRAIN: wait until the pipeline is empty, then go to DONE.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, then return to IDLE.
- Timing, with start sampled at edge 0:
  - First en is at edge 1.
  - Last en is at edge count.
  - done is high in cycle count+RD_LAT+1.
  - busy is high during edges 1..count+RD_LAT.
  - For count=0, done is high at edge 1.
- Compare arithmetic:
  - diff = sign-extended (got - exp) in DATA_W+1 bits.
  - |diff| is computed in DATA_W+1 bits unsigned.
  - Mismatch if |diff| > zero-extended tol.
  - tol=0 gives an exact compare.
  - Extremes such as -128 vs 127 (diff 255) must not overflow.
- err_cnt increments by 1 per mismatch and holds at 2^ERR_W-1.
- first_err_*:
  - Written only on the first mismatch of a sweep.
  - first_err_vld is set at the same time.
- Results (err_cnt, first_err_*) hold after done until the next accepted start.
- Data values outside compare cycles are don't-care and must not affect the results.

Test Plan:
- Matching data: RD_LAT=3, base=0, count=24, tol=0, both RAMs loaded identically. Required: done in cycle 28 after start; err_cnt=0; first_err_vld=0; exactly 24 en cycles, addresses 0..23.
- Injected errors: as above, but the result RAM has addr 5 = -3 (golden 4) and addr 17 = 100 (golden 99). Required: err_cnt=2; first_err_addr=5; exp=4; got=-3.
- Tolerance: same data as the injected-error case, tol=1. Required: err_cnt=1 (only addr 5); first_err_addr=5. Extreme check: got=-128, exp=127, tol=127 must count as an error.
- Wrap and edge counts:
  - base=0xFFFE, count=4 gives addresses FFFE, FFFF, 0000, 0001.
  - count=0 gives done the next cycle with err_cnt=0 and no en.
  - A start during busy is ignored.
- Saturation and latency: ERR_W=4, count=20, all words mismatched. Required: err_cnt=15. Repeat with RD_LAT=1 and RD_LAT=7; done cycle = count+RD_LAT+1.
- Reset mid-sweep: rst_n=0 at address 10 of 24. Required: all outputs 0 immediately and no done pulse. A new start afterwards completes normally.
